// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   ARB_ADDR_W  : default address width
//   ARB_LINE_W  : default cache-line width
//   rr_pick()   : round-robin selection over up to ARB_MAX_REQ requesters
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_ADDR_W    = 64;
    localparam int ARB_LINE_W    = 512;

    // rr_pick works on a fixed-size request vector so one function serves every
    // NUM_REQ; callers zero-extend their valid vector and truncate the index.
    localparam int ARB_MAX_REQ   = 32;
    localparam int ARB_IDX_MAX_W = 5;
    localparam int ARB_CAND_W    = ARB_IDX_MAX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                     found;
        logic [ARB_IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo num_req.
    // ptr is always < num_req, so one conditional subtraction wraps the index.
    function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0]   valid,
                                         input logic [ARB_IDX_MAX_W-1:0] ptr,
                                         input int unsigned              num_req);
        rr_pick_t              r;
        logic [ARB_CAND_W-1:0] cand;
        r = '0;
        for (int unsigned k = 0; k < ARB_MAX_REQ; k++) begin
            cand = {1'b0, ptr} + ARB_CAND_W'(k);
            if (cand >= ARB_CAND_W'(num_req)) begin
                cand = cand - ARB_CAND_W'(num_req);
            end
            if (!r.found && (k < num_req) && valid[cand[ARB_IDX_MAX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[ARB_IDX_MAX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker.
//   valid       in  NUM_REQ  request vector
//   ptr         in  IDX_W    highest-priority requester index
//   grant_idx   out IDX_W    chosen requester (meaningful when grant_found=1)
//   grant_found out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_found
);

    logic [ARB_MAX_REQ-1:0]   valid_ext;
    rr_pick_t                 pick;
    // Upper index bits are always zero for NUM_REQ below ARB_MAX_REQ.
    logic [ARB_IDX_MAX_W-1:0] unused_pick_idx;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        pick                     = rr_pick(valid_ext, ARB_IDX_MAX_W'(ptr), NUM_REQ);
    end

    assign grant_idx       = pick.idx[IDX_W-1:0];
    assign grant_found     = pick.found;
    assign unused_pick_idx = pick.idx;

endmodule

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
// Round-robin arbiter between NUM_REQ cache requesters (0 = icache,
// 1 = dcache) and a single memory-controller port, one transaction in flight.
// Also forwards snoop invalidates to the dcache with one cycle of latency.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/req_wr [NUM_REQ]       per-requester request and write flag
//   req_addr/req_wdata (packed)      requester i at [i*W +: W]
//   req_done [NUM_REQ]               one-hot completion pulse
//   rsp_data                         read data, valid while req_done != 0
//   mem_req/mem_wr_en/mem_address/mem_data_out   memory request side
//   mem_data_valid/data_from_mem     memory completion and read data
//   invalidate_cache(_addr)          snoop from memory controller
//   dcache_invalidate(_addr)         forwarded snoop
//
// Handshake: a requester raises req_valid[i] and holds it (with address, data,
// write flag) until the cycle req_done[i]=1; the transaction completes on that
// edge, and the requester may drop or replace its request there. The memory
// side sees a one-cycle mem_req pulse with address/data/write qualifier held
// stable until completion; one mem_data_valid cycle in WAIT completes it.
// -----------------------------------------------------------------------------
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int LINE_W      = ARB_LINE_W,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LINE_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [LINE_W-1:0]           rsp_data,
    output logic                        mem_req,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [LINE_W-1:0]           mem_data_out,
    input  logic                        mem_data_valid,
    input  logic [LINE_W-1:0]           data_from_mem,
    input  logic                        invalidate_cache,
    input  logic [ADDR_W-1:0]           invalidate_cache_addr,
    output logic                        dcache_invalidate,
    output logic [ADDR_W-1:0]           dcache_invalidate_addr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [LINE_W-1:0]  mem_data_out_q, mem_data_out_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic [LINE_W-1:0]  rsp_data_q, rsp_data_d;
    logic               dcache_invalidate_q, dcache_invalidate_d;
    logic [ADDR_W-1:0]  dcache_invalidate_addr_q, dcache_invalidate_addr_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               timeout_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .valid       (req_valid),
        .ptr         (rr_ptr_q),
        .grant_idx   (pick_idx),
        .grant_found (pick_found)
    );

    assign timeout_hit = (TIMEOUT_CYC > 0) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d                  = state_q;
        grant_d                  = grant_q;
        rr_ptr_d                 = rr_ptr_q;
        tmo_d                    = '0;
        mem_req_d                = 1'b0;
        mem_wr_en_d              = mem_wr_en_q;
        mem_address_d            = mem_address_q;
        mem_data_out_d           = mem_data_out_q;
        req_done_d               = '0;
        rsp_data_d               = rsp_data_q;
        dcache_invalidate_d      = invalidate_cache;
        dcache_invalidate_addr_d = dcache_invalidate_addr_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d        = pick_idx;
                    mem_address_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    mem_data_out_d = req_wdata[pick_idx*LINE_W +: LINE_W];
                    mem_wr_en_d    = req_wr[pick_idx];
                    // mem_req is registered, so it is raised on entry to ISSUE.
                    mem_req_d      = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_data_valid) begin
                    rsp_data_d = data_from_mem;
                    req_done_d = NUM_REQ'(1) << grant_q;
                    state_d    = DONE;
                end else if (timeout_hit) begin
                    // Counter clears via the default; reissue the held request.
                    mem_req_d = 1'b1;
                    state_d   = ISSUE;
                end else if (TIMEOUT_CYC > 0) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (invalidate_cache) begin
            dcache_invalidate_addr_d = invalidate_cache_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                  <= IDLE;
            grant_q                  <= '0;
            rr_ptr_q                 <= '0;
            tmo_q                    <= '0;
            mem_req_q                <= 1'b0;
            mem_wr_en_q              <= 1'b0;
            mem_address_q            <= '0;
            mem_data_out_q           <= '0;
            req_done_q               <= '0;
            rsp_data_q               <= '0;
            dcache_invalidate_q      <= 1'b0;
            dcache_invalidate_addr_q <= '0;
        end else begin
            state_q                  <= state_d;
            grant_q                  <= grant_d;
            rr_ptr_q                 <= rr_ptr_d;
            tmo_q                    <= tmo_d;
            mem_req_q                <= mem_req_d;
            mem_wr_en_q              <= mem_wr_en_d;
            mem_address_q            <= mem_address_d;
            mem_data_out_q           <= mem_data_out_d;
            req_done_q               <= req_done_d;
            rsp_data_q               <= rsp_data_d;
            dcache_invalidate_q      <= dcache_invalidate_d;
            dcache_invalidate_addr_q <= dcache_invalidate_addr_d;
        end
    end

    assign req_done               = req_done_q;
    assign rsp_data               = rsp_data_q;
    assign mem_req                = mem_req_q;
    assign mem_wr_en              = mem_wr_en_q;
    assign mem_address            = mem_address_q;
    assign mem_data_out           = mem_data_out_q;
    assign dcache_invalidate      = dcache_invalidate_q;
    assign dcache_invalidate_addr = dcache_invalidate_addr_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: instance a (NUM_REQ=2, TIMEOUT_CYC=4, full widths)
// and instance b (NUM_REQ=3, no timeout, narrow widths). Expected memory
// requests, completions and forwarded invalidates are queued with the cycle
// they must appear in; monitors on the falling edge pop and compare.
module tb_mem_arbiter_rr;

    typedef struct {
        logic [63:0]  addr;   // address, or done vector for completions
        logic         wr;
        logic [511:0] data;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance a ----------------
    logic [1:0]    a_req_valid, a_req_wr, a_req_done;
    logic [127:0]  a_req_addr;
    logic [1023:0] a_req_wdata;
    logic [511:0]  a_rsp_data, a_mem_data_out, a_mem_rdata;
    logic          a_mem_req, a_mem_wr_en, a_mem_valid;
    logic [63:0]   a_mem_address, a_inv_addr, a_dinv_addr;
    logic          a_inv, a_dinv;

    mem_arbiter_rr #(.NUM_REQ(2), .ADDR_W(64), .LINE_W(512), .TIMEOUT_CYC(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_wr(a_req_wr), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .req_done(a_req_done), .rsp_data(a_rsp_data),
        .mem_req(a_mem_req), .mem_wr_en(a_mem_wr_en), .mem_address(a_mem_address),
        .mem_data_out(a_mem_data_out), .mem_data_valid(a_mem_valid), .data_from_mem(a_mem_rdata),
        .invalidate_cache(a_inv), .invalidate_cache_addr(a_inv_addr),
        .dcache_invalidate(a_dinv), .dcache_invalidate_addr(a_dinv_addr)
    );

    // ---------------- instance b ----------------
    logic [2:0]   b_req_valid, b_req_wr, b_req_done;
    logic [47:0]  b_req_addr;
    logic [95:0]  b_req_wdata;
    logic [31:0]  b_rsp_data, b_mem_data_out, b_mem_rdata;
    logic         b_mem_req, b_mem_wr_en, b_mem_valid;
    logic [15:0]  b_mem_address, b_inv_addr, b_dinv_addr;
    logic         b_inv, b_dinv;

    mem_arbiter_rr #(.NUM_REQ(3), .ADDR_W(16), .LINE_W(32), .TIMEOUT_CYC(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_wr(b_req_wr), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_done(b_req_done), .rsp_data(b_rsp_data),
        .mem_req(b_mem_req), .mem_wr_en(b_mem_wr_en), .mem_address(b_mem_address),
        .mem_data_out(b_mem_data_out), .mem_data_valid(b_mem_valid), .data_from_mem(b_mem_rdata),
        .invalidate_cache(b_inv), .invalidate_cache_addr(b_inv_addr),
        .dcache_invalidate(b_dinv), .dcache_invalidate_addr(b_dinv_addr)
    );

    // ---------------- scoreboard ----------------
    exp_t a_mreq_q[$];
    exp_t a_done_q[$];
    exp_t a_inv_q[$];
    exp_t b_mreq_q[$];
    exp_t b_done_q[$];

    function automatic exp_t mk(input logic [63:0] addr, input logic wr,
                                input logic [511:0] data, input int c);
        exp_t e;
        e.addr = addr;
        e.wr   = wr;
        e.data = data;
        e.cyc  = c;
        return e;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_a_mreq
        exp_t e;
        if (a_mem_req === 1'b1) begin
            if (a_mreq_q.size() == 0) miss("a_mreq_extra");
            else begin
                e = a_mreq_q.pop_front();
                chk("a_mreq_cyc", 512'(cyc), 512'(e.cyc));
                chk("a_mreq_addr", 512'(a_mem_address), 512'(e.addr));
                chk("a_mreq_wr", 512'(a_mem_wr_en), 512'(e.wr));
                chk("a_mreq_data", a_mem_data_out, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_a_done
        exp_t e;
        if (a_req_done != 2'b00) begin
            if (a_done_q.size() == 0) miss("a_done_extra");
            else begin
                e = a_done_q.pop_front();
                chk("a_done_cyc", 512'(cyc), 512'(e.cyc));
                chk("a_done_vec", 512'(a_req_done), 512'(e.addr));
                chk("a_done_rsp", a_rsp_data, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_a_inv
        exp_t e;
        if (a_dinv === 1'b1) begin
            if (a_inv_q.size() == 0) miss("a_inv_extra");
            else begin
                e = a_inv_q.pop_front();
                chk("a_inv_cyc", 512'(cyc), 512'(e.cyc));
                chk("a_inv_addr", 512'(a_dinv_addr), 512'(e.addr));
            end
        end
    end

    always @(negedge clk) begin : mon_b_mreq
        exp_t e;
        if (b_mem_req === 1'b1) begin
            if (b_mreq_q.size() == 0) miss("b_mreq_extra");
            else begin
                e = b_mreq_q.pop_front();
                chk("b_mreq_cyc", 512'(cyc), 512'(e.cyc));
                chk("b_mreq_addr", 512'(b_mem_address), 512'(e.addr));
            end
        end
    end

    always @(negedge clk) begin : mon_b_done
        exp_t e;
        if (b_req_done != 3'b000) begin
            if (b_done_q.size() == 0) miss("b_done_extra");
            else begin
                e = b_done_q.pop_front();
                chk("b_done_cyc", 512'(cyc), 512'(e.cyc));
                chk("b_done_vec", 512'(b_req_done), 512'(e.addr));
                chk("b_done_rsp", 512'(b_rsp_data), e.data);
            end
        end
    end

    // ---------------- memory responders ----------------
    int a_lat = 2;
    int a_rsp_at = -1;
    int a_man_at = -1;
    bit a_auto = 1'b1;
    int b_rsp_at = -1;

    initial begin : resp_a
        a_mem_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            a_mem_valid = (cyc == a_rsp_at) || (cyc == a_man_at);
            if (a_auto && a_mem_req === 1'b1) a_rsp_at = cyc + a_lat;
        end
    end

    initial begin : resp_b
        b_mem_valid = 1'b0;
        b_mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            b_mem_valid = (cyc == b_rsp_at);
            b_mem_rdata = {16'hD00D, b_mem_address};
            if (b_mem_req === 1'b1) b_rsp_at = cyc + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic reset_and_check(input string tag);
        tick();
        rst = 1'b1;
        #2;
        chk({tag, "_mem_req"}, 512'(a_mem_req), 512'(0));
        chk({tag, "_mem_wr_en"}, 512'(a_mem_wr_en), 512'(0));
        chk({tag, "_mem_address"}, 512'(a_mem_address), 512'(0));
        chk({tag, "_mem_data_out"}, a_mem_data_out, 512'(0));
        chk({tag, "_req_done"}, 512'(a_req_done), 512'(0));
        chk({tag, "_rsp_data"}, a_rsp_data, 512'(0));
        chk({tag, "_dinv"}, 512'(a_dinv), 512'(0));
        chk({tag, "_dinv_addr"}, 512'(a_dinv_addr), 512'(0));
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin : main
        int t;
        int g;
        int g_seq[8];
        logic [511:0] fill_cc;
        g_seq = '{0, 1, 2, 0, 2, 0, 2, 0};
        fill_cc = {16{32'hCCCCCCCC}};

        rst = 1'b0;
        a_req_valid = '0; a_req_wr = '0; a_req_addr = '0; a_req_wdata = '0;
        a_mem_rdata = '0; a_inv = 1'b0; a_inv_addr = '0;
        b_req_valid = '0; b_req_wr = '0; b_req_addr = '0; b_req_wdata = '0;
        b_inv = 1'b0; b_inv_addr = '0;

        reset_and_check("rst0");

        // Single read from icache, memory answers two cycles after mem_req.
        tick(); t = cyc;
        a_req_valid = 2'b01; a_req_wr = 2'b00;
        a_req_addr  = {64'h0, 64'h1000};
        a_mem_rdata = {16{32'hAAAAAAAA}};
        a_mreq_q.push_back(mk(64'h1000, 1'b0, '0, t + 1));
        a_done_q.push_back(mk(64'h1, 1'b0, {16{32'hAAAAAAAA}}, t + 4));
        wait_until(t + 5);
        a_req_valid = 2'b00;

        // Reset with non-zero datapath state.
        reset_and_check("rst1");

        // Both requesters held; requester 1 writes. Grants alternate 0,1,0,1.
        tick(); t = cyc;
        a_req_valid = 2'b11; a_req_wr = 2'b10;
        a_req_addr  = {64'h3000, 64'h2000};
        a_req_wdata = {{16{32'h55555555}}, 512'h0};
        a_mem_rdata = fill_cc;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            a_mreq_q.push_back(mk((g == 0) ? 64'h2000 : 64'h3000, (g == 1),
                                  (g == 0) ? 512'h0 : {16{32'h55555555}}, t + 1 + 5 * k));
            a_done_q.push_back(mk((g == 0) ? 64'h1 : 64'h2, 1'b0, fill_cc, t + 4 + 5 * k));
        end
        wait_until(t + 20);
        a_req_valid = 2'b00; a_req_wr = 2'b00; a_req_wdata = '0;

        // Timeout: memory silent, mem_req reissued every 5 cycles, answer at t+12.
        tick(); t = cyc;
        a_auto = 1'b0;
        a_man_at = t + 12;
        a_req_valid = 2'b01;
        a_req_addr  = {64'h0, 64'h4000};
        a_mem_rdata = {16{32'hDDDDDDDD}};
        a_mreq_q.push_back(mk(64'h4000, 1'b0, '0, t + 1));
        a_mreq_q.push_back(mk(64'h4000, 1'b0, '0, t + 6));
        a_mreq_q.push_back(mk(64'h4000, 1'b0, '0, t + 11));
        a_done_q.push_back(mk(64'h1, 1'b0, {16{32'hDDDDDDDD}}, t + 13));
        wait_until(t + 14);
        a_req_valid = 2'b00;
        a_auto = 1'b1;

        // Reset during WAIT of a grant to requester 1; stray response follows.
        tick(); t = cyc;
        a_lat = 6;
        a_req_valid = 2'b11;
        a_req_addr  = {64'h5000, 64'h6000};
        a_mem_rdata = {16{32'hEEEEEEEE}};
        a_mreq_q.push_back(mk(64'h5000, 1'b0, '0, t + 1));
        wait_until(t + 2);
        a_req_valid = 2'b00;
        reset_and_check("rst_wait");
        wait_until(t + 10);
        t = cyc;
        a_lat = 2;
        a_req_valid = 2'b11;
        a_mem_rdata = {16{32'h77777777}};
        a_mreq_q.push_back(mk(64'h6000, 1'b0, '0, t + 1));
        a_done_q.push_back(mk(64'h1, 1'b0, {16{32'h77777777}}, t + 4));
        wait_until(t + 5);
        a_req_valid = 2'b00;

        // Invalidate burst overlapping DONE; arbiter timing must be unaffected.
        tick(); t = cyc;
        a_req_valid = 2'b01;
        a_req_addr  = {64'h0, 64'h7000};
        a_mem_rdata = {16{32'h99999999}};
        a_mreq_q.push_back(mk(64'h7000, 1'b0, '0, t + 1));
        a_done_q.push_back(mk(64'h1, 1'b0, {16{32'h99999999}}, t + 4));
        wait_until(t + 3);
        a_inv = 1'b1; a_inv_addr = 64'h40;
        a_inv_q.push_back(mk(64'h40, 1'b0, '0, t + 4));
        tick();
        a_inv_addr = 64'h80;
        a_inv_q.push_back(mk(64'h80, 1'b0, '0, t + 5));
        tick();
        a_inv_addr = 64'hC0;
        a_inv_q.push_back(mk(64'hC0, 1'b0, '0, t + 6));
        a_req_valid = 2'b00;
        tick();
        a_inv = 1'b0; a_inv_addr = 64'h1234;
        wait_until(t + 8);
        chk("a_inv_addr_hold", 512'(a_dinv_addr), 512'(64'hC0));
        chk("a_inv_low", 512'(a_dinv), 512'(0));

        // Three requesters: grants 0,1,2,0 then with requester 1 dropped 2,0,2,0.
        tick(); t = cyc;
        b_req_valid = 3'b111;
        b_req_addr  = {16'h0300, 16'h0200, 16'h0100};
        for (int k = 0; k < 8; k++) begin
            g = g_seq[k];
            b_mreq_q.push_back(mk(64'(16'h0100 * (g + 1)), 1'b0, '0, t + 1 + 4 * k));
            b_done_q.push_back(mk(64'(1 << g), 1'b0, 512'({16'hD00D, 16'(16'h0100 * (g + 1))}),
                                  t + 3 + 4 * k));
        end
        wait_until(t + 16);
        b_req_valid = 3'b101;
        wait_until(t + 32);
        b_req_valid = 3'b000;

        // Drain and confirm every expected event was seen.
        wait_until(cyc + 6);
        chk("a_mreq_left", 512'(a_mreq_q.size()), 512'(0));
        chk("a_done_left", 512'(a_done_q.size()), 512'(0));
        chk("a_inv_left", 512'(a_inv_q.size()), 512'(0));
        chk("b_mreq_left", 512'(b_mreq_q.size()), 512'(0));
        chk("b_done_left", 512'(b_done_q.size()), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-requester arbiter between the L1 caches (icache, dcache, future prefetcher/PTW ports) and the single memory-controller port.
- Round-robin grant, one outstanding memory transaction at a time, line-wide read and write support.
- Per-requester completion handshake and optional timeout/reissue.
- Forwards memory-controller invalidation (snoop) requests to the dcache with a fixed one-cycle latency.

Parameters:
- NUM_REQ, 2, number of requester ports; index 0 = icache, 1 = dcache.
- ADDR_W, 64, address width.
- LINE_W, 512, cache-line data width.
- TIMEOUT_CYC, 0, cycles in WAIT before mem_req is reissued; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request, held until completion.
- req_wr  in  NUM_REQ  per-requester write flag.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*LINE_W  packed write data, same packing rule.
- req_done  out  NUM_REQ  one-hot completion pulse.
- rsp_data  out  LINE_W  read data, shared by all requesters; valid when any req_done bit is 1.
- mem_req  out  1  one-cycle request pulse to the memory controller.
- mem_wr_en  out  1  write qualifier.
- mem_address  out  ADDR_W  memory address.
- mem_data_out  out  LINE_W  write data to memory.
- mem_data_valid  in  1  memory completion (read data or write acknowledge).
- data_from_mem  in  LINE_W  read data from memory.
- invalidate_cache  in  1  snoop invalidate pulse from the memory controller.
- invalidate_cache_addr  in  ADDR_W  snoop address.
- dcache_invalidate  out  1  forwarded invalidate.
- dcache_invalidate_addr  out  ADDR_W  forwarded snoop address.

Behaviour:
- Reset: every output is 0. state=IDLE, rr_ptr=0, timeout counter=0. Reset asserted mid-transaction aborts it with no req_done; the memory response that follows is ignored because the FSM is in IDLE.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_valid is set, grant the first set bit at or after rr_ptr, wrapping modulo NUM_REQ. On the clock edge:
  - latch the grant index, req_addr, req_wdata and req_wr into mem_address, mem_data_out and mem_wr_en;
  - go to ISSUE.
- ISSUE: mem_req=1 for exactly this cycle. mem_address, mem_data_out and mem_wr_en hold stable from ISSUE through DONE. Next state is WAIT.
- WAIT:
  - mem_data_valid=1 captures data_from_mem into rsp_data (also for writes; the value is don't-care) and moves to DONE.
  - If TIMEOUT_CYC>0, the counter increments each WAIT cycle. At count==TIMEOUT_CYC-1 with no mem_data_valid, return to ISSUE (reissue mem_req) and clear the counter.
- mem_data_valid in IDLE, ISSUE or DONE is ignored.
- DONE:
  - req_done[grant]=1 for exactly one cycle; rsp_data is stable.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - Next state is IDLE.
- Handshake: a transaction completes on the edge where req_done[i]=1. The requester may drop req_valid[i] or present a new request on that edge. The next IDLE cycle samples the new value.
- Latency: request accepted in IDLE, mem_req the next cycle. req_done follows one cycle after the mem_data_valid edge. With zero memory latency the minimum turnaround is 4 cycles per transaction.
- If the granted requester drops req_valid before DONE, the transaction still completes on the memory side. req_done is still pulsed and the requester must ignore it.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- Invalidate path runs independently of the FSM:
  - dcache_invalidate <= invalidate_cache; dcache_invalidate_addr <= invalidate_cache_addr when invalidate_cache=1, otherwise it holds its value.
  - Back-to-back pulses are forwarded cycle-for-cycle.
  - A pulse coinciding with any arbiter state, including DONE, is not delayed or dropped.
- Width rules: the grant index is $clog2(NUM_REQ) bits wide (minimum 1 bit). Index arithmetic wraps; there is no out-of-range grant.

Decomposition:
- arb_pkg holds:
  - the state enum arb_state_t (IDLE, ISSUE, WAIT, DONE);
  - default constants ARB_ADDR_W=64 and ARB_LINE_W=512;
  - the function rr_pick(valid, ptr), returning the index plus a found flag.
- Sub-module rr_arbiter (combinational, parameter NUM_REQ; inputs valid and ptr; outputs grant_idx and grant_found) isolates the priority logic for unit test. The FSM, datapath registers and invalidate path stay in mem_arbiter_rr.

Test Plan:
- Single read, NUM_REQ=2:
  - stimulus: req_valid=01, addr0=0x1000; memory returns 0xAA..AA two cycles after mem_req.
  - required: mem_req one cycle with mem_address=0x1000, mem_wr_en=0; req_done=01 one cycle with rsp_data=0xAA..AA.
- Simultaneous requests:
  - stimulus: req_valid=11 held, req_wr[1]=1 with wdata 0x55..55.
  - required: grant order 0,1,0,1; second transaction has mem_wr_en=1 and mem_data_out=0x55..55; each req_done is one-hot.
- Timeout, TIMEOUT_CYC=4:
  - stimulus: memory silent for 10 cycles, then valid.
  - required: mem_req pulses at ISSUE and reissues every 5 cycles (4 WAIT + ISSUE); exactly one req_done.
- Reset mid-WAIT, then stray response:
  - stimulus: rst asserted during WAIT; mem_data_valid arrives after reset.
  - required: all outputs 0; no req_done; next request granted from requester 0.
- Invalidate during DONE:
  - stimulus: invalidate_cache pulsed on 3 consecutive cycles, addrs 0x40, 0x80, 0xC0.
  - required: dcache_invalidate high 3 cycles, delayed by 1; addresses in order; arbiter timing unchanged.
- NUM_REQ=3, all valid, rr_ptr wrap:
  - required: grants 0,1,2,0.
  - then drop req_valid[1]: required grants 2,0,2,0.
